// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter and its future read-side sibling.
package fifo_wr_arbiter_pkg;

    localparam int DSIZE_DEF     = 8;
    localparam int NREQ_DEF      = 4;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side valid/ready bundle plus the FIFO write port, shared by arbiter and its environment.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  wfull;

    // Environment side: producers and the FIFO full flag.
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after last_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);
    int j;

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(last_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[IW'(j)]) begin
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port between NREQ valid/ready producers.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int DSIZE     = DSIZE_DEF,
    parameter  int NREQ      = NREQ_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int IW        = $clog2(NREQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus,
    output logic [IW-1:0]     gnt_id,
    output logic              busy
);
    arb_state_e    state_q, state_d;
    logic [IW-1:0] last_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          xfer;
    logic          rel;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req      (bus.req_valid),
        .last_ptr (last_q),
        .gnt_idx  (pick_idx),
        .gnt_any  (pick_any)
    );

    // Gated by wrst so nothing reaches the FIFO while reset is being applied.
    assign xfer = (state_q == BURST) && !wrst && bus.req_valid[gnt_id] && !bus.wfull;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
            gnt_id  <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_any) begin
                gnt_id <= pick_idx;
                cnt_q  <= '0;
            end
            if (xfer) cnt_q <= cnt_q + 1'b1;
            if (rel)  last_q <= gnt_id;
        end
    end

    // A stall on wfull is not a release; only last word, burst limit or dropped valid end the grant.
    always_comb begin
        state_d = state_q;
        rel     = 1'b0;
        unique case (state_q)
            IDLE:  if (pick_any) state_d = BURST;
            BURST: begin
                if (!bus.req_valid[gnt_id] ||
                    (xfer && (bus.req_last[gnt_id] || cnt_q == CW'(MAX_BURST - 1)))) begin
                    state_d = IDLE;
                    rel     = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.winc      = 1'b0;
        bus.wdata     = '0;
        busy          = (state_q == BURST);
        if (xfer) begin
            bus.req_ready[gnt_id] = 1'b1;
            bus.winc              = 1'b1;
            bus.wdata             = bus.req_data[gnt_id*DSIZE +: DSIZE];
        end
    end
endmodule
